fwd_scoreboard_checker: RTL and testbench
=========================================

Name: fwd_scoreboard_checker

Overview:
- Parametrised successor to the single-pipeline ALU forwarding checker. Keeps a shadow copy of the register addresses for EX and for FWD_DEPTH later write-back stages.
- Each cycle EX advances, it computes the expected value of every register-sourced ALU operand and compares it with the operand the datapath actually used.
- Expected value: the youngest matching stage result, otherwise register-file read data.
- Bound next to the RV32IMA core for simulation and formal runs. Produces sticky error status, a first-error capture and error counters.

Parameters:
XLEN, 32, datapath width of operands and stage results
NUM_OPERANDS, 2, number of checked ALU operands (rs1, rs2, ...)
FWD_DEPTH, 2, number of forwarding source stages after EX (index 0 = MEM, youngest)
ERR_CNT_W, 16, width of the saturating error counter

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
stall_i  in  1  1 = ID/EX register holds, bubble inserted into first post-EX stage
flush_i  in  1  1 = ID/EX entry replaced by bubble (priority over stall_i for EX entry)
clear_i  in  1  clears sticky error and capture registers (counter kept)
id_valid_i  in  1  ID holds a real instruction
rs_addr_id_i  in  NUM_OPERANDS*5  source register addresses in ID, operand j at [5j+:5]
rs_used_id_i  in  NUM_OPERANDS  operand j is register-sourced (0 = imm/PC, not checked)
rd_addr_id_i  in  5  destination register in ID
reg_write_id_i  in  1  instruction in ID writes rd
rf_data_ex_i  in  NUM_OPERANDS*XLEN  register-file read data presented in EX
fwd_data_i  in  FWD_DEPTH*XLEN  result of stage k at [XLEN*k+:XLEN]
alu_in_i  in  NUM_OPERANDS*XLEN  operands actually applied to ALU in EX
chk_valid_o  out  1  a check was performed this cycle
err_pulse_o  out  1  at least one operand mismatched this cycle
err_sticky_o  out  1  set on first error, held until clear_i/reset
err_operand_o  out  NUM_OPERANDS  mismatching operand mask, captured at first error
err_src_o  out  $clog2(FWD_DEPTH+1)  source of first error: 0 = regfile, k+1 = stage k
err_exp_o  out  XLEN  expected value at first error (lowest-index failing operand)
err_act_o  out  XLEN  actual value at first error
err_count_o  out  ERR_CNT_W  count of erroneous check cycles, saturates at all-ones

Behaviour:
- Reset (clk edge with reset=1): all shadow valid bits 0; all outputs 0; state RUN.
- EX entry update: flush_i -> valid=0. Else !stall_i -> load {id_valid_i, rs, rs_used, rd, reg_write}. Else hold.
- Stage 0 update: stall_i|flush_i -> bubble (valid=0). Else copy from EX. Stage k>0 always copies from stage k-1; these stages are never stalled.
- Writer k qualifies if valid & reg_write & rd!=0.
- Expected operand j: youngest qualifying stage k with rd==rs_j gives fwd_data_i[k]. If none qualifies, use rf_data_ex_i[j]. rs_j==0 always uses rf data.
- Check is combinational in the EX cycle. chk_valid_o = EX.valid & !stall_i & !flush_i. Operands with rs_used=0 are masked out.
- err_pulse_o = chk_valid_o & |mismatch. Registered outputs (sticky/capture/count) update on the next edge.
- State machine:
  - RUN: on an error pulse, capture mask/src/exp/act, set sticky, go to FAULT.
  - FAULT: no recapture; counter still increments.
  - clear_i in FAULT returns to RUN and zeroes capture regs.
  - clear_i and an error pulse in the same cycle: the capture wins, state stays FAULT.
- Counter increments by 1 per error cycle, saturating.
- Reset mid-run discards all in-flight shadow entries. No check fires until a new instruction reaches EX.

Decomposition:
- Package fwd_chk_pkg: stage-entry struct {valid, rd, reg_write}, EX-entry struct, and the SRC_REGFILE constant.
- One sub-module, fwd_chk_select: combinational youngest-match priority selector for one operand. Instantiated NUM_OPERANDS times via generate.

Test Plan:
- Distance-1 RAW: x5 written via stage 0 (fwd_data[0]=0x1234), consumer rs1=x5, alu_in a=0x1234 -> chk_valid_o=1, err_pulse_o=0.
- Both stages write x5 (stage0=0xAAAA, stage1=0xBBBB), alu_in a=0xBBBB -> err_pulse_o=1, err_src_o=1, err_exp_o=0xAAAA, err_act_o=0xBBBB, err_count_o=1 next cycle.
- Writer rd=x0 with fwd_data[0]=0xFFFF, consumer rs2=x0, rf data 0, alu_in b=0 -> no error.
- stall_i=1 for 3 cycles with valid EX -> chk_valid_o=0 during stall, exactly one check on release, stage 0 shows bubbles.
- flush_i on the cycle a mismatching instruction would enter EX -> no check, err_count_o stays 0.
- Two errors, then clear_i -> sticky/capture hold the first error until clear; err_count_o=2 after clear; a third error recaptures.

Source files
------------

// File: rtl/fwd_chk_pkg.sv
// Shared types for the forwarding scoreboard checker: shadow pipeline entries,
// checker state encoding and the "source = register file" code.
package fwd_chk_pkg;

  localparam int REG_ADDR_W  = 5;
  localparam int SRC_REGFILE = 0;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
  } stage_entry_t;

  // Destination half of the EX shadow entry; source addresses live beside it
  // because their count is a module parameter.
  typedef struct packed {
    logic                  valid;
    logic                  reg_write;
    logic [REG_ADDR_W-1:0] rd;
  } ex_entry_t;

  typedef enum logic {
    ST_RUN,
    ST_FAULT
  } chk_state_t;

  function automatic stage_entry_t ex_to_stage(input ex_entry_t e);
    stage_entry_t s;
    s.valid     = e.valid;
    s.rd        = e.rd;
    s.reg_write = e.reg_write;
    return s;
  endfunction

  function automatic logic writer_qualifies(input stage_entry_t s);
    return s.valid && s.reg_write && (s.rd != '0);
  endfunction

endpackage

// File: rtl/fwd_chk_select.sv
// Youngest-match forwarding selector for one ALU operand: picks the result of
// the youngest qualifying writer stage, else the register-file read data.
module fwd_chk_select
  import fwd_chk_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int FWD_DEPTH = 2,
  parameter int SRC_W     = 2
) (
  input  logic [REG_ADDR_W-1:0]           rs_addr,
  input  logic [FWD_DEPTH-1:0]            stg_qual,
  input  logic [FWD_DEPTH*REG_ADDR_W-1:0] stg_rd,
  input  logic [FWD_DEPTH*XLEN-1:0]       fwd_data,
  input  logic [XLEN-1:0]                 rf_data,
  output logic [XLEN-1:0]                 exp_data,
  output logic [SRC_W-1:0]                src
);

  // Walk oldest to youngest so the last hit (the youngest stage) wins.
  always_comb begin
    exp_data = rf_data;
    src      = SRC_W'(SRC_REGFILE);
    for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
      if ((rs_addr != '0) && stg_qual[k] &&
          (stg_rd[k*REG_ADDR_W +: REG_ADDR_W] == rs_addr)) begin
        exp_data = fwd_data[k*XLEN +: XLEN];
        src      = SRC_W'(k + 1);
      end
    end
  end

endmodule

// File: rtl/fwd_scoreboard_checker.sv
// Shadow-pipeline checker that recomputes every register-sourced ALU operand in
// EX and flags disagreement with what the datapath forwarded.
module fwd_scoreboard_checker
  import fwd_chk_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int NUM_OPERANDS = 2,
  parameter int FWD_DEPTH    = 2,
  parameter int ERR_CNT_W    = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              stall_i,
  input  logic                              flush_i,
  input  logic                              clear_i,
  input  logic                              id_valid_i,
  input  logic [NUM_OPERANDS*5-1:0]         rs_addr_id_i,
  input  logic [NUM_OPERANDS-1:0]           rs_used_id_i,
  input  logic [4:0]                        rd_addr_id_i,
  input  logic                              reg_write_id_i,
  input  logic [NUM_OPERANDS*XLEN-1:0]      rf_data_ex_i,
  input  logic [FWD_DEPTH*XLEN-1:0]         fwd_data_i,
  input  logic [NUM_OPERANDS*XLEN-1:0]      alu_in_i,
  output logic                              chk_valid_o,
  output logic                              err_pulse_o,
  output logic                              err_sticky_o,
  output logic [NUM_OPERANDS-1:0]           err_operand_o,
  output logic [$clog2(FWD_DEPTH+1)-1:0]    err_src_o,
  output logic [XLEN-1:0]                   err_exp_o,
  output logic [XLEN-1:0]                   err_act_o,
  output logic [ERR_CNT_W-1:0]              err_count_o
);

  localparam int SRC_W = $clog2(FWD_DEPTH + 1);

  ex_entry_t                          ex_reg;
  logic [NUM_OPERANDS*REG_ADDR_W-1:0] ex_rs_reg;
  logic [NUM_OPERANDS-1:0]            ex_used_reg;
  stage_entry_t [FWD_DEPTH-1:0]       stage_reg;

  logic [FWD_DEPTH-1:0]               stg_qual;
  logic [FWD_DEPTH*REG_ADDR_W-1:0]    stg_rd;
  logic [NUM_OPERANDS*XLEN-1:0]       exp_vec;
  logic [NUM_OPERANDS*SRC_W-1:0]      src_vec;
  logic [NUM_OPERANDS-1:0]            mismatch;
  logic                               chk_valid;
  logic                               err_pulse;
  logic                               do_capture;
  logic [SRC_W-1:0]                   first_src;
  logic [XLEN-1:0]                    first_exp;
  logic [XLEN-1:0]                    first_act;

  chk_state_t                         state_reg;
  logic                               sticky_reg;
  logic [NUM_OPERANDS-1:0]            mask_reg;
  logic [SRC_W-1:0]                   src_reg;
  logic [XLEN-1:0]                    exp_reg;
  logic [XLEN-1:0]                    act_reg;
  logic [ERR_CNT_W-1:0]               count_reg;

  // EX shadow: flush beats stall; a stalled entry simply holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_reg      <= '0;
      ex_rs_reg   <= '0;
      ex_used_reg <= '0;
    end else if (flush_i) begin
      ex_reg.valid <= 1'b0;
    end else if (!stall_i) begin
      ex_reg.valid     <= id_valid_i;
      ex_reg.reg_write <= reg_write_id_i;
      ex_reg.rd        <= rd_addr_id_i;
      ex_rs_reg        <= rs_addr_id_i;
      ex_used_reg      <= rs_used_id_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stage_reg[0] <= '0;
    end else if (stall_i || flush_i) begin
      stage_reg[0] <= '0;
    end else begin
      stage_reg[0] <= ex_to_stage(ex_reg);
    end
  end

  genvar gi;
  generate
    for (gi = 1; gi < FWD_DEPTH; gi++) begin : g_stage
      always_ff @(posedge clk) begin
        if (reset) begin
          stage_reg[gi] <= '0;
        end else begin
          stage_reg[gi] <= stage_reg[gi-1];
        end
      end
    end

    for (gi = 0; gi < FWD_DEPTH; gi++) begin : g_qual
      assign stg_qual[gi]                         = writer_qualifies(stage_reg[gi]);
      assign stg_rd[gi*REG_ADDR_W +: REG_ADDR_W]  = stage_reg[gi].rd;
    end

    for (gi = 0; gi < NUM_OPERANDS; gi++) begin : g_opnd
      fwd_chk_select #(
        .XLEN      (XLEN),
        .FWD_DEPTH (FWD_DEPTH),
        .SRC_W     (SRC_W)
      ) u_select (
        .rs_addr  (ex_rs_reg[gi*REG_ADDR_W +: REG_ADDR_W]),
        .stg_qual (stg_qual),
        .stg_rd   (stg_rd),
        .fwd_data (fwd_data_i),
        .rf_data  (rf_data_ex_i[gi*XLEN +: XLEN]),
        .exp_data (exp_vec[gi*XLEN +: XLEN]),
        .src      (src_vec[gi*SRC_W +: SRC_W])
      );
      assign mismatch[gi] = ex_used_reg[gi] &&
                            (alu_in_i[gi*XLEN +: XLEN] != exp_vec[gi*XLEN +: XLEN]);
    end
  endgenerate

  assign chk_valid = ex_reg.valid && !stall_i && !flush_i;
  assign err_pulse = chk_valid && (|mismatch);

  // Report details of the lowest-index failing operand.
  always_comb begin
    first_src = '0;
    first_exp = '0;
    first_act = '0;
    for (int j = NUM_OPERANDS - 1; j >= 0; j--) begin
      if (mismatch[j]) begin
        first_src = src_vec[j*SRC_W +: SRC_W];
        first_exp = exp_vec[j*XLEN +: XLEN];
        first_act = alu_in_i[j*XLEN +: XLEN];
      end
    end
  end

  // A new error recaptures in RUN, or in FAULT when it coincides with clear.
  assign do_capture = err_pulse && ((state_reg == ST_RUN) || clear_i);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= ST_RUN;
      sticky_reg <= 1'b0;
      mask_reg   <= '0;
      src_reg    <= '0;
      exp_reg    <= '0;
      act_reg    <= '0;
      count_reg  <= '0;
    end else begin
      if (err_pulse && (count_reg != '1)) begin
        count_reg <= count_reg + 1'b1;
      end
      if (do_capture) begin
        state_reg  <= ST_FAULT;
        sticky_reg <= 1'b1;
        mask_reg   <= mismatch;
        src_reg    <= first_src;
        exp_reg    <= first_exp;
        act_reg    <= first_act;
      end else if ((state_reg == ST_FAULT) && clear_i) begin
        state_reg  <= ST_RUN;
        sticky_reg <= 1'b0;
        mask_reg   <= '0;
        src_reg    <= '0;
        exp_reg    <= '0;
        act_reg    <= '0;
      end
    end
  end

  assign chk_valid_o   = chk_valid;
  assign err_pulse_o   = err_pulse;
  assign err_sticky_o  = sticky_reg;
  assign err_operand_o = mask_reg;
  assign err_src_o     = src_reg;
  assign err_exp_o     = exp_reg;
  assign err_act_o     = act_reg;
  assign err_count_o   = count_reg;

endmodule

// File: tb/tb_fwd_scoreboard_checker.sv
// Directed bench for the forwarding scoreboard checker: hand-built pipeline
// sequences with hand-computed expected status, capture and counter values.
module tb_fwd_scoreboard_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_i, flush_i, clear_i;
  logic        id_valid_i;
  logic [9:0]  rs_addr_id_i;
  logic [1:0]  rs_used_id_i;
  logic [4:0]  rd_addr_id_i;
  logic        reg_write_id_i;
  logic [63:0] rf_data_ex_i;
  logic [63:0] fwd_data_i;
  logic [63:0] alu_in_i;
  logic        chk_valid_o, err_pulse_o, err_sticky_o;
  logic [1:0]  err_operand_o;
  logic [1:0]  err_src_o;
  logic [31:0] err_exp_o, err_act_o;
  logic [2:0]  err_count_o;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  fwd_scoreboard_checker #(
    .XLEN(32), .NUM_OPERANDS(2), .FWD_DEPTH(2), .ERR_CNT_W(3)
  ) dut (
    .clk(clk), .reset(reset), .stall_i(stall_i), .flush_i(flush_i), .clear_i(clear_i),
    .id_valid_i(id_valid_i), .rs_addr_id_i(rs_addr_id_i), .rs_used_id_i(rs_used_id_i),
    .rd_addr_id_i(rd_addr_id_i), .reg_write_id_i(reg_write_id_i),
    .rf_data_ex_i(rf_data_ex_i), .fwd_data_i(fwd_data_i), .alu_in_i(alu_in_i),
    .chk_valid_o(chk_valid_o), .err_pulse_o(err_pulse_o), .err_sticky_o(err_sticky_o),
    .err_operand_o(err_operand_o), .err_src_o(err_src_o), .err_exp_o(err_exp_o),
    .err_act_o(err_act_o), .err_count_o(err_count_o)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic id_set(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [1:0] used, input logic [4:0] rd, input logic we);
    id_valid_i     = v;
    rs_addr_id_i   = {r2, r1};
    rs_used_id_i   = used;
    rd_addr_id_i   = rd;
    reg_write_id_i = we;
    if (v) $display("issue: rs1=x%0d rs2=x%0d used=%b rd=x%0d we=%0b", r1, r2, used, rd, we);
  endtask

  task automatic ex_set(input logic [31:0] rfa, input logic [31:0] rfb, input logic [31:0] f0,
                        input logic [31:0] f1, input logic [31:0] a, input logic [31:0] b);
    rf_data_ex_i = {rfb, rfa};
    fwd_data_i   = {f1, f0};
    alu_in_i     = {b, a};
    #1;
  endtask

  task automatic ex_zero();
    ex_set(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; stall_i = 1'b0; flush_i = 1'b0; clear_i = 1'b0;
    id_set(0, 0, 0, 0, 0, 0);
    ex_zero();
    step(); step();
    reset = 1'b0;
    #1;
    check_val("rst_chk_valid", chk_valid_o, 0);
    check_val("rst_pulse", err_pulse_o, 0);
    check_val("rst_sticky", err_sticky_o, 0);
    check_val("rst_count", err_count_o, 0);
    check_val("rst_mask", err_operand_o, 0);
    check_val("rst_src", err_src_o, 0);
    check_val("rst_exp", err_exp_o, 0);
    check_val("rst_act", err_act_o, 0);

    // Distance-1 RAW through stage 0
    id_set(1, 0, 0, 2'b00, 5, 1); step(); ex_zero();
    check_val("raw1_writer_chk", chk_valid_o, 1);
    check_val("raw1_writer_pulse", err_pulse_o, 0);
    id_set(1, 5, 0, 2'b01, 6, 0); step(); ex_set(32'h9999, 0, 32'h1234, 0, 32'h1234, 0);
    check_val("raw1_chk", chk_valid_o, 1);
    check_val("raw1_pulse", err_pulse_o, 0);
    id_set(0, 0, 0, 0, 0, 0); step(); ex_zero();
    check_val("raw1_bubble_chk", chk_valid_o, 0);
    step(); ex_zero();

    // Two writers of x5: youngest (stage 0) must win
    id_set(1, 0, 0, 2'b00, 5, 1); step(); ex_zero();
    id_set(1, 0, 0, 2'b00, 5, 1); step(); ex_zero();
    id_set(1, 5, 0, 2'b01, 7, 0); step(); ex_set(0, 0, 32'hAAAA, 32'hBBBB, 32'hBBBB, 0);
    check_val("young_chk", chk_valid_o, 1);
    check_val("young_pulse", err_pulse_o, 1);
    id_set(0, 0, 0, 0, 0, 0); step(); ex_zero();
    check_val("young_sticky", err_sticky_o, 1);
    check_val("young_mask", err_operand_o, 2'b01);
    check_val("young_src", err_src_o, 1);
    check_val("young_exp", err_exp_o, 32'hAAAA);
    check_val("young_act", err_act_o, 32'hBBBB);
    check_val("young_count", err_count_o, 1);
    clear_i = 1'b1; step(); clear_i = 1'b0; ex_zero();
    check_val("clr1_sticky", err_sticky_o, 0);
    check_val("clr1_exp", err_exp_o, 0);
    check_val("clr1_mask", err_operand_o, 0);
    check_val("clr1_count", err_count_o, 1);
    step(); ex_zero();

    // x0 writer must never forward
    id_set(1, 0, 0, 2'b00, 0, 1); step(); ex_zero();
    id_set(1, 0, 0, 2'b10, 8, 0); step(); ex_set(0, 0, 32'hFFFF, 0, 0, 0);
    check_val("x0_chk", chk_valid_o, 1);
    check_val("x0_pulse", err_pulse_o, 0);
    id_set(0, 0, 0, 0, 0, 0); step(); ex_zero();
    check_val("x0_count", err_count_o, 1);
    step(); ex_zero();

    // Stall: three held cycles, stage 0 bubbles flush out the stale writer
    id_set(1, 0, 0, 2'b00, 7, 1); step(); ex_zero();
    id_set(1, 7, 0, 2'b01, 9, 0); step();
    stall_i = 1'b1;
    id_set(0, 0, 0, 0, 0, 0);
    ex_set(32'h55, 0, 32'h77, 32'h77, 32'h55, 0);
    for (int i = 0; i < 3; i++) begin
      check_val($sformatf("stall%0d_chk", i), chk_valid_o, 0);
      check_val($sformatf("stall%0d_pulse", i), err_pulse_o, 0);
      step();
    end
    stall_i = 1'b0;
    #1;
    check_val("stall_rel_chk", chk_valid_o, 1);
    check_val("stall_rel_pulse", err_pulse_o, 0);
    step(); ex_zero();
    check_val("stall_once_chk", chk_valid_o, 0);
    check_val("stall_count", err_count_o, 1);

    // Flush into EX, then flush of a valid EX entry
    id_set(1, 3, 0, 2'b01, 0, 0); flush_i = 1'b1; step(); flush_i = 1'b0;
    ex_set(1, 0, 0, 0, 2, 0);
    check_val("flush_in_chk", chk_valid_o, 0);
    check_val("flush_in_pulse", err_pulse_o, 0);
    step(); flush_i = 1'b1; ex_set(1, 0, 0, 0, 2, 0);
    check_val("flush_ex_chk", chk_valid_o, 0);
    check_val("flush_ex_pulse", err_pulse_o, 0);
    id_set(0, 0, 0, 0, 0, 0); step(); flush_i = 1'b0; ex_zero();
    check_val("flush_count", err_count_o, 1);
    check_val("flush_sticky", err_sticky_o, 0);

    // Back-to-back errors, capture holds the first one
    id_set(1, 4, 6, 2'b11, 0, 0); step(); ex_set(32'h10, 32'h20, 0, 0, 32'h11, 32'h21);
    check_val("e1_pulse", err_pulse_o, 1);
    id_set(1, 4, 0, 2'b01, 0, 0); step(); ex_set(32'h30, 0, 0, 0, 32'h31, 0);
    check_val("e1_sticky", err_sticky_o, 1);
    check_val("e1_mask", err_operand_o, 2'b11);
    check_val("e1_src", err_src_o, 0);
    check_val("e1_exp", err_exp_o, 32'h10);
    check_val("e1_act", err_act_o, 32'h11);
    check_val("e1_count", err_count_o, 2);
    check_val("e2_pulse", err_pulse_o, 1);
    id_set(1, 0, 9, 2'b10, 0, 0); step(); ex_set(0, 32'h40, 0, 0, 0, 32'h41);
    check_val("e2_hold_exp", err_exp_o, 32'h10);
    check_val("e2_hold_mask", err_operand_o, 2'b11);
    check_val("e2_count", err_count_o, 3);
    // Clear coinciding with an error: the new error is captured
    clear_i = 1'b1; id_set(0, 0, 0, 0, 0, 0); step(); clear_i = 1'b0; ex_zero();
    check_val("e3_sticky", err_sticky_o, 1);
    check_val("e3_mask", err_operand_o, 2'b10);
    check_val("e3_exp", err_exp_o, 32'h40);
    check_val("e3_act", err_act_o, 32'h41);
    check_val("e3_count", err_count_o, 4);
    clear_i = 1'b1; step(); clear_i = 1'b0; ex_zero();
    check_val("clr2_sticky", err_sticky_o, 0);
    check_val("clr2_mask", err_operand_o, 0);
    check_val("clr2_act", err_act_o, 0);
    check_val("clr2_count", err_count_o, 4);

    // Recapture in RUN from stage 1 (distance 2)
    id_set(1, 0, 0, 2'b00, 5, 1); step(); ex_zero();
    id_set(0, 0, 0, 0, 0, 0); step(); ex_zero();
    id_set(1, 5, 0, 2'b01, 0, 0); step(); ex_set(0, 0, 32'hD0, 32'hC0, 32'hC1, 0);
    check_val("e4_pulse", err_pulse_o, 1);
    id_set(0, 0, 0, 0, 0, 0); step(); ex_zero();
    check_val("e4_sticky", err_sticky_o, 1);
    check_val("e4_src", err_src_o, 2);
    check_val("e4_exp", err_exp_o, 32'hC0);
    check_val("e4_act", err_act_o, 32'hC1);
    check_val("e4_count", err_count_o, 5);

    // Three more error cycles: counter saturates at 7
    id_set(1, 1, 0, 2'b01, 0, 0); step(); ex_set(1, 0, 0, 0, 2, 0);
    step(); step();
    id_set(0, 0, 0, 0, 0, 0); step(); ex_zero();
    check_val("sat_count", err_count_o, 7);
    check_val("sat_hold_exp", err_exp_o, 32'hC0);

    // Reset mid-run discards the in-flight EX entry
    id_set(1, 1, 0, 2'b01, 0, 0); step(); ex_set(1, 0, 0, 0, 2, 0);
    reset = 1'b1; id_set(0, 0, 0, 0, 0, 0); step(); reset = 1'b0; #1;
    check_val("mrst_chk", chk_valid_o, 0);
    check_val("mrst_pulse", err_pulse_o, 0);
    check_val("mrst_sticky", err_sticky_o, 0);
    check_val("mrst_count", err_count_o, 0);
    check_val("mrst_exp", err_exp_o, 0);
    step();
    check_val("mrst_idle_chk", chk_valid_o, 0);
    check_val("mrst_idle_count", err_count_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
